// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single unified memory port between the instruction fetch stage
//   (IF) and the memory stage (MEM). One transaction is in flight at a time:
//   IDLE picks a requester, BUSY_I/BUSY_D hold the request on the bus until
//   mem_ack (or a wait-counter timeout), and RESP returns a one-cycle
//   completion pulse to the served port.
//
//   Data requests win ties because they belong to the older instruction.
//   A taken branch (flush_if) cancels a stale fetch: a fetch that has not
//   started is never issued, and a fetch already on the bus finishes there
//   but its completion pulse is withheld. Timeouts complete with bus_err and
//   a safe value (NOP for fetch, 0 for data).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr/flush_if         fetch request side
//   if_rdata/if_valid/if_stall      fetch response side
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data request side
//   dm_rdata/dm_valid/dm_stall      data response side
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request (registered)
//   mem_rdata/mem_ack               memory response
//   bus_err                         one-cycle pulse on timeout completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            flush_if,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_valid,
    output logic            dm_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT-1; keep at least one bit.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);

    state_t        stateR;
    state_t        nextStateS;
    logic [CW-1:0] waitCntR;
    logic          killedR;     // fetch in flight was cancelled by a branch
    logic          ifValidR;
    logic          timeoutS;
    logic          doneS;

    assign timeoutS = (waitCntR == CNT_LAST);
    assign doneS    = mem_ack | timeoutS;

    // A branch during the RESP cycle itself must still cancel the pulse,
    // so the registered pulse is gated by the live flush.
    assign if_valid = ifValidR & ~flush_if;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state logic: data first, stale fetches are never issued.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE: begin
                if (dm_req) begin
                    nextStateS = BUSY_D;
                end else if (if_req && !flush_if) begin
                    nextStateS = BUSY_I;
                end else begin
                    nextStateS = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (doneS) begin
                    nextStateS = RESP;
                end else begin
                    nextStateS = stateR;
                end
            end
            RESP:    nextStateS = IDLE;
            default: nextStateS = IDLE;
        endcase
    end

    // Registered bus drive, wait counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            ifValidR  <= 1'b0;
            dm_valid  <= 1'b0;
            bus_err   <= 1'b0;
            waitCntR  <= '0;
            killedR   <= 1'b0;
        end else begin
            ifValidR <= 1'b0;
            dm_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (stateR)
                IDLE: begin
                    waitCntR <= '0;
                    killedR  <= 1'b0;
                    if (dm_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end else if (if_req && !flush_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (stateR == BUSY_I && flush_if) begin
                        killedR <= 1'b1;
                    end else begin
                        killedR <= killedR;
                    end
                    if (doneS) begin
                        // An ack on the final counter value still counts as success.
                        mem_req  <= 1'b0;
                        waitCntR <= '0;
                        bus_err  <= ~mem_ack;
                        if (stateR == BUSY_I) begin
                            if_rdata <= mem_ack ? mem_rdata : NOP_INSN;
                            ifValidR <= ~(killedR | flush_if);
                        end else begin
                            dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        waitCntR <= waitCntR + CW'(1);
                    end
                end
                RESP: begin
                    mem_req  <= 1'b0;
                    waitCntR <= '0;
                end
                default: begin
                    mem_req  <= 1'b0;
                    waitCntR <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=4). The stimulus process
//   issues requests and pushes the expected completion (port, data, error,
//   cycle) into a queue; a monitor pops and compares whenever a valid pulse
//   appears. A memory responder acks after a programmable number of BUSY
//   cycles, returning data from a small fixed table.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush_if;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    mem_port_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err)
    );

    typedef struct {
        bit          isData;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } resp_t;

    resp_t expQ[$];
    int    passCnt  = 0;
    int    totalCnt = 0;
    int    cyc      = 0;
    int    ackDelay = 0;     // -1: never ack
    bit    forceAck = 1'b0;  // stray ack injection

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0300: return 32'h00A0_0113;
            32'h0000_2000: return 32'hDEAD_BEEF;
            32'h0000_2004: return 32'hCAFE_F00D;
            default:       return 32'h5555_AAAA;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passCnt++;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pushExp(input bit isData, input logic [31:0] rdata, input bit err, input int c);
        resp_t e;
        e.isData = isData;
        e.rdata  = rdata;
        e.err    = err;
        e.cyc    = c;
        expQ.push_back(e);
    endtask

    // Memory responder: acks after ackDelay BUSY cycles.
    initial begin : responder
        int waitC;
        waitC     = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = forceAck;
            if (mem_req && rst_n) begin
                if (ackDelay >= 0 && waitC == ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memRead(mem_addr);
                end
                waitC++;
            end else begin
                waitC = 0;
            end
        end
    end

    // Monitor: every completion pulse must match the head of the queue.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (if_valid || dm_valid)) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_valid", {62'd0, if_valid, dm_valid}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("resp_port", {62'd0, if_valid, dm_valid}, e.isData ? 64'd1 : 64'd2);
                    chk("resp_rdata", e.isData ? {32'd0, dm_rdata} : {32'd0, if_rdata}, {32'd0, e.rdata});
                    chk("resp_bus_err", {63'd0, bus_err}, {63'd0, e.err});
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic runTimeout(input bit isData, input logic [31:0] a);
        int t0;
        ackDelay = -1;
        nextCycle();
        t0 = cyc;
        if (isData) begin
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        pushExp(isData, isData ? 32'h0 : 32'h0000_0013, 1'b1, t0 + 5);
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            sample();
            chk("timeout_mem_req_held", {63'd0, mem_req}, 64'd1);
        end
        nextCycle();
        sample();
        chk("timeout_mem_req_dropped", {63'd0, mem_req}, 64'd0);
        nextCycle();
        dm_req = 1'b0;
        if_req = 1'b0;
        sample();
        chk("timeout_bus_err_pulse", {63'd0, bus_err}, 64'd0);
    endtask

    initial begin : stim
        int t0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush_if = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
        repeat (2) nextCycle();
        sample();
        chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
        chk("reset_outputs", {if_rdata, dm_rdata}, 64'd0);
        chk("reset_pulses", {60'd0, if_valid, dm_valid, bus_err, mem_we}, 64'd0);
        nextCycle();
        rst_n = 1'b1;

        // 1: fetch only, zero-wait ack
        ackDelay = 0;
        nextCycle();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        pushExp(1'b0, 32'h0050_0093, 1'b0, t0 + 2);
        sample();
        chk("t1_stall_c0", {63'd0, if_stall}, 64'd1);
        chk("t1_mem_req_c0", {63'd0, mem_req}, 64'd0);
        nextCycle();
        sample();
        chk("t1_mem_req_c1", {63'd0, mem_req}, 64'd1);
        chk("t1_mem_bus_c1", {27'd0, mem_we, mem_be, mem_addr}, {27'd0, 1'b0, 4'hF, 32'h100});
        chk("t1_stall_c1", {63'd0, if_stall}, 64'd1);
        nextCycle();
        sample();
        chk("t1_stall_c2", {63'd0, if_stall}, 64'd0);
        chk("t1_mem_req_c2", {63'd0, mem_req}, 64'd0);
        nextCycle();
        if_req = 1'b0;
        sample();
        chk("t1_rdata_hold", {32'd0, if_rdata}, {32'd0, 32'h0050_0093});

        // 2: simultaneous requests, data first
        nextCycle();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        pushExp(1'b1, 32'hDEAD_BEEF, 1'b0, t0 + 2);
        pushExp(1'b0, 32'h00A0_0113, 1'b0, t0 + 5);
        nextCycle();
        sample();
        chk("t2_data_addr", {31'd0, mem_we, mem_addr}, {31'd0, 1'b0, 32'h2000});
        nextCycle();
        sample();
        chk("t2_if_stall_while_data", {62'd0, if_stall, dm_stall}, 64'd2);
        nextCycle();
        dm_req = 1'b0;
        sample();
        chk("t2_gap_mem_req", {63'd0, mem_req}, 64'd0);
        nextCycle();
        sample();
        chk("t2_fetch_mem_req_c4", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h300});
        nextCycle();
        nextCycle();
        if_req = 1'b0;

        // data timeout after a real load: returns 0 with bus_err
        runTimeout(1'b1, 32'h2000);

        // 3: store, ack in third BUSY cycle
        ackDelay = 2;
        nextCycle();
        t0 = cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'h1234; dm_be = 4'b0011;
        pushExp(1'b1, 32'h0, 1'b0, t0 + 4);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            sample();
            chk("t3_store_bus", {mem_req, mem_we, mem_be, 26'd0, mem_wdata},
                {1'b1, 1'b1, 4'b0011, 26'd0, 32'h1234});
        end
        nextCycle();
        nextCycle();
        dm_req = 1'b0; dm_we = 1'b0;

        // 4: flush while BUSY_I, ack on the last allowed wait cycle
        ackDelay = 3;
        nextCycle();
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        nextCycle();
        flush_if = 1'b1; if_req = 1'b0;
        sample();
        chk("t4_mem_req_c1", {63'd0, mem_req}, 64'd1);
        for (int i = 2; i <= 4; i++) begin
            nextCycle();
            flush_if = 1'b0;
            sample();
            chk("t4_mem_req_continues", {63'd0, mem_req}, 64'd1);
        end
        nextCycle();
        sample();
        chk("t4_resp_no_valid_no_err", {61'd0, if_valid, bus_err, mem_req}, 64'd0);
        nextCycle();
        sample();
        chk("t4_idle_mem_req", {63'd0, mem_req}, 64'd0);

        // 4b: flush during RESP of a fetch
        ackDelay = 0;
        nextCycle();
        if_req = 1'b1; if_addr = 32'h300;
        nextCycle();
        nextCycle();
        flush_if = 1'b1;
        sample();
        chk("t4b_valid_suppressed", {63'd0, if_valid}, 64'd0);
        nextCycle();
        flush_if = 1'b0; if_req = 1'b0;

        // 5: fetch timeout
        runTimeout(1'b0, 32'h400);

        // stray ack in IDLE is ignored
        sample();
        forceAck = 1'b1;
        sample();
        forceAck = 1'b0;
        nextCycle();
        sample();
        chk("stray_ack_ignored", {31'd0, mem_req, if_rdata}, {31'd0, 1'b0, 32'h0000_0013});

        // 6: reset during BUSY_D
        ackDelay = 1;
        nextCycle();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        nextCycle();
        sample();
        chk("t6_mem_req_before_reset", {63'd0, mem_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_mem_req_async_drop", {63'd0, mem_req}, 64'd0);
        nextCycle();
        dm_req = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t6_idle_after_reset", {62'd0, mem_req, dm_valid}, 64'd0);
            nextCycle();
        end

        sample();
        chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
